// File: rtl/tcp_rx_seq_ctrl_if.sv
// tcp_rx_seq_ctrl_if: header, payload, reorder-buffer and status signals of the rx sequencing controller
interface tcp_rx_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEQ_BITS   = 32,
  parameter int CNT_BITS   = 16
);
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [SEQ_BITS-1:0]   hdr_seq;
  logic [15:0]           hdr_len;
  logic                  hdr_syn;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] rb_tdata;
  logic                  rb_tvalid;
  logic                  rb_tlast;
  logic                  rb_tready;
  logic [SEQ_BITS-1:0]   rb_seq_start;
  logic [SEQ_BITS-1:0]   rb_seq_base;
  logic                  rb_base_valid;
  logic [31:0]           rb_window;
  logic                  dlv_fire;
  logic [SEQ_BITS-1:0]   rcv_nxt;
  logic                  synced;
  logic [CNT_BITS-1:0]   drop_cnt;
  logic [CNT_BITS-1:0]   dup_cnt;
  logic [CNT_BITS-1:0]   len_err_cnt;
  modport master (
    output hdr_valid, hdr_seq, hdr_len, hdr_syn, s_tdata, s_tvalid, s_tlast,
           rb_tready, rb_window, dlv_fire,
    input  hdr_ready, s_tready, rb_tdata, rb_tvalid, rb_tlast, rb_seq_start,
           rb_seq_base, rb_base_valid, rcv_nxt, synced, drop_cnt, dup_cnt, len_err_cnt
  );
  modport slave (
    input  hdr_valid, hdr_seq, hdr_len, hdr_syn, s_tdata, s_tvalid, s_tlast,
           rb_tready, rb_window, dlv_fire,
    output hdr_ready, s_tready, rb_tdata, rb_tvalid, rb_tlast, rb_seq_start,
           rb_seq_base, rb_base_valid, rcv_nxt, synced, drop_cnt, dup_cnt, len_err_cnt
  );
endinterface

// File: rtl/tcp_rx_seq_ctrl.sv
// tcp_rx_seq_ctrl: SYN sync, window admission and payload forwarding in front of the reorder buffer
module tcp_rx_seq_ctrl #(
  parameter int SEQ_BITS = 32,
  parameter int CNT_BITS = 16
) (
  input logic clk,
  input logic rst,
  tcp_rx_seq_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, SYNC = 3'd2, FWD = 3'd3, DROP = 3'd4;
  logic [2:0]          state_q, state_d;
  logic [SEQ_BITS-1:0] seq_q, seq_start_q, seq_base_q, rcv_nxt_q;
  logic [15:0]         len_q, bcnt_q;
  logic                syn_q, synced_q;
  logic [CNT_BITS-1:0] drop_q, dup_q, lerr_q;
  logic [SEQ_BITS-1:0] off;
  logic [SEQ_BITS:0]   end_w;
  logic                fire, last_beat, too_far, drop_inc, dup_inc, lerr_inc;
  assign off       = seq_q - rcv_nxt_q;
  assign end_w     = {1'b0, off} + {{(SEQ_BITS-15){1'b0}}, len_q};
  assign too_far   = end_w > {{(SEQ_BITS-31){1'b0}}, bus.rb_window};
  assign last_beat = bcnt_q == len_q - 16'd1;
  assign fire      = bus.s_tvalid && bus.s_tready;
  assign drop_inc  = state_q == CHECK && !syn_q && (!synced_q || (!off[SEQ_BITS-1] && too_far));
  assign dup_inc   = state_q == CHECK && !syn_q && synced_q && off[SEQ_BITS-1];
  assign bus.hdr_ready     = state_q == IDLE;
  assign bus.s_tready      = state_q == FWD ? bus.rb_tready : state_q == DROP;
  assign bus.rb_tdata      = bus.s_tdata;
  assign bus.rb_tvalid     = state_q == FWD && bus.s_tvalid;
  assign bus.rb_tlast      = state_q == FWD && (bus.s_tlast || last_beat);
  assign bus.rb_base_valid = state_q == SYNC;
  assign bus.rb_seq_start  = seq_start_q;
  assign bus.rb_seq_base   = seq_base_q;
  assign bus.rcv_nxt       = rcv_nxt_q;
  assign bus.synced        = synced_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.dup_cnt       = dup_q;
  assign bus.len_err_cnt   = lerr_q;
  // next state; a length error is a mismatch between the counted last beat and tlast
  always_comb begin
    state_d  = state_q;
    lerr_inc = 1'b0;
    case (state_q)
      IDLE:  state_d = bus.hdr_valid ? CHECK : IDLE;
      CHECK: state_d = syn_q ? SYNC : len_q == 16'd0 ? IDLE : (drop_inc || dup_inc) ? DROP : FWD;
      SYNC:  state_d = len_q != 16'd0 ? DROP : IDLE;
      FWD: begin
        if (fire && (last_beat || bus.s_tlast)) begin
          state_d  = (last_beat && !bus.s_tlast) ? DROP : IDLE;
          lerr_inc = last_beat != bus.s_tlast;
        end
      end
      DROP:    state_d = (bus.s_tvalid && bus.s_tlast) ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  // state, latched header, sequence tracking and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      len_q       <= '0;
      syn_q       <= 1'b0;
      bcnt_q      <= '0;
      seq_start_q <= '0;
      seq_base_q  <= '0;
      rcv_nxt_q   <= '0;
      synced_q    <= 1'b0;
      drop_q      <= '0;
      dup_q       <= '0;
      lerr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.hdr_valid) begin
        seq_q <= bus.hdr_seq;
        len_q <= bus.hdr_len;
        syn_q <= bus.hdr_syn;
      end
      if (state_q == CHECK) begin
        bcnt_q <= '0;
        if (syn_q) seq_base_q <= seq_q + 1'b1;
        if (state_d == FWD) seq_start_q <= seq_q;
      end
      if (state_q == FWD && fire) bcnt_q <= bcnt_q + 16'd1;
      if (state_q == SYNC) begin
        rcv_nxt_q <= seq_q + 1'b1;
        synced_q  <= 1'b1;
      end else if (bus.dlv_fire && synced_q) begin
        rcv_nxt_q <= rcv_nxt_q + 1'b1;
      end
      drop_q <= drop_q + CNT_BITS'(drop_inc && ~&drop_q);
      dup_q  <= dup_q + CNT_BITS'(dup_inc && ~&dup_q);
      lerr_q <= lerr_q + CNT_BITS'(lerr_inc && ~&lerr_q);
    end
  end
endmodule
